keypad_scan_ctrl: RTL and testbench

Parametrised 4x4 matrix-keypad scanner and decimal entry accumulator, successor to the fixed 3-column single-rate keypad reader.
- Drives active-low columns from a single-clock scan tick; no derived clocks.
- Debounces in the scan domain and emits exactly one event per physical press.
- Accumulates a DIGITS-wide decimal value with clear, backspace and enter/commit.
- Feeds the timer/display logic with a committed preset value.

---
 rtl/keypad_pkg.sv | 60 ++++++
 rtl/keypad_scan_ctrl_if.sv | 24 ++
 rtl/keypad_digit_acc.sv | 70 +++++++
 rtl/keypad_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and entry accumulator.
//   - ROWS/COLS: matrix geometry
//   - KEY_*: 4-bit key codes reported on key_code
//   - scan_state_e: scan FSM states
//   - key_map(): (row, col) -> key code
package keypad_pkg;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;

   typedef logic [3:0] key_code_t;

   // Digits encode as their own value so the accumulator can add the code directly.
   localparam key_code_t KEY_0    = 4'd0;
   localparam key_code_t KEY_1    = 4'd1;
   localparam key_code_t KEY_2    = 4'd2;
   localparam key_code_t KEY_3    = 4'd3;
   localparam key_code_t KEY_4    = 4'd4;
   localparam key_code_t KEY_5    = 4'd5;
   localparam key_code_t KEY_6    = 4'd6;
   localparam key_code_t KEY_7    = 4'd7;
   localparam key_code_t KEY_8    = 4'd8;
   localparam key_code_t KEY_9    = 4'd9;
   localparam key_code_t KEY_A    = 4'd10;
   localparam key_code_t KEY_B    = 4'd11;
   localparam key_code_t KEY_C    = 4'd12;
   localparam key_code_t KEY_D    = 4'd13;
   localparam key_code_t KEY_STAR = 4'd14;
   localparam key_code_t KEY_HASH = 4'd15;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StHold
   } scan_state_e;

   function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
      key_code_t code;
      unique case ({row, col})
         4'h0:    code = KEY_1;
         4'h1:    code = KEY_2;
         4'h2:    code = KEY_3;
         4'h3:    code = KEY_A;
         4'h4:    code = KEY_4;
         4'h5:    code = KEY_5;
         4'h6:    code = KEY_6;
         4'h7:    code = KEY_B;
         4'h8:    code = KEY_7;
         4'h9:    code = KEY_8;
         4'hA:    code = KEY_9;
         4'hB:    code = KEY_C;
         4'hC:    code = KEY_STAR;
         4'hD:    code = KEY_0;
         4'hE:    code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scanner bus: matrix lines plus the key event / entry value outputs.
//   master: the scanner (drives columns and results, reads rows)
//   slave:  the keypad model / consumer side
interface keypad_scan_ctrl_if #(
   parameter int unsigned VAL_W = 14
);
   logic [3:0]       row_n;
   logic [3:0]       col_n;
   logic             key_valid;
   logic [3:0]       key_code;
   logic [VAL_W-1:0] value;
   logic [VAL_W-1:0] committed;
   logic             commit;

   modport master (
      input  row_n,
      output col_n, key_valid, key_code, value, committed, commit
   );

   modport slave (
      output row_n,
      input  col_n, key_valid, key_code, value, committed, commit
   );
endinterface

// File: rtl/keypad_digit_acc.sv
// Decimal entry accumulator.
//   clk, rst   clock, async active-high reset
//   key_valid  strobe, registered into value/committed on the same edge
//   key_code   key code qualified by key_valid
//   value      current entry, modulo 10^DIGITS
//   committed  value latched on '#'
//   commit     one-cycle pulse when committed updates
module keypad_digit_acc
   import keypad_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned VAL_W  = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  key_code_t        key_code,
   output logic [VAL_W-1:0] value,
   output logic [VAL_W-1:0] committed,
   output logic             commit
);

   // Four spare bits keep value*10+9 exact before reduction.
   localparam int unsigned ProdW = VAL_W + 4;
   localparam logic [ProdW-1:0] Modulus = ProdW'(10 ** DIGITS);

   logic [VAL_W-1:0] value_q, value_d;
   logic [VAL_W-1:0] committed_q, committed_d;
   logic             commit_q, commit_d;
   logic [ProdW-1:0] prod;

   always_comb begin
      value_d     = value_q;
      committed_d = committed_q;
      commit_d    = 1'b0;
      prod        = {4'b0000, value_q} * ProdW'(10) + ProdW'(key_code);
      if (key_valid) begin
         if (key_code <= KEY_9) begin
            value_d = VAL_W'(prod % Modulus);
         end else begin
            case (key_code)
               KEY_STAR: value_d = '0;
               KEY_D:    value_d = value_q / VAL_W'(10);
               KEY_HASH: begin
                  committed_d = value_q;
                  commit_d    = 1'b1;
               end
               default:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q     <= '0;
         committed_q <= '0;
         commit_q    <= 1'b0;
      end else begin
         value_q     <= value_d;
         committed_q <= committed_d;
         commit_q    <= commit_d;
      end
   end

   assign value     = value_q;
   assign committed = committed_q;
   assign commit    = commit_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with debounce and decimal entry accumulation.
//   clk, rst  clock, async active-high reset
//   kp        keypad bus (master): row_n in; col_n, key_valid, key_code,
//             value, committed, commit out
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 1000000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned VAL_W          = 14
) (
   input  logic         clk,
   input  logic         rst,
   keypad_scan_ctrl_if.master kp
);

   localparam int unsigned DivW = $clog2(CLK_DIV);
   localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_SCANS);

   logic [3:0]      row_meta_q, row_sync_q;
   logic [DivW-1:0] div_q;
   logic            tick;

   scan_state_e     state_q, state_d;
   logic [1:0]      col_q, col_d;
   logic [1:0]      cap_row_q, cap_row_d;
   logic [CntW-1:0] dcnt_q, dcnt_d;
   logic [CntW-1:0] hcnt_q, hcnt_d;
   logic            kv_q, kv_d;
   key_code_t       code_q, code_d;

   logic [3:0]      row_low;
   logic [1:0]      low_idx;
   logic [3:0]      col_n_w;
   logic [VAL_W-1:0] value_w, committed_w;
   logic            commit_w;

   // Rows idle high, so the synchroniser resets to all-released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= kp.row_n;
         row_sync_q <= row_meta_q;
      end
   end

   assign tick = (div_q == DivW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DivW'(1);
      end
   end

   assign row_low = ~row_sync_q;

   always_comb begin
      low_idx = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         if (row_low[i]) low_idx = 2'(i);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StScan;
         col_q     <= '0;
         cap_row_q <= '0;
         dcnt_q    <= '0;
         hcnt_q    <= '0;
         kv_q      <= 1'b0;
         code_q    <= KEY_0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         cap_row_q <= cap_row_d;
         dcnt_q    <= dcnt_d;
         hcnt_q    <= hcnt_d;
         kv_q      <= kv_d;
         code_q    <= code_d;
      end
   end

   // Next-state logic; everything moves only on the scan tick.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      cap_row_d = cap_row_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      kv_d      = 1'b0;
      code_d    = code_q;
      if (tick) begin
         unique case (state_q)
            StScan: begin
               // Zero or several low rows (ghosting) are treated alike: move on.
               if ($onehot(row_low)) begin
                  cap_row_d = low_idx;
                  dcnt_d    = CntW'(1);
                  state_d   = StDebounce;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
            StDebounce: begin
               if (row_low == (4'b0001 << cap_row_q)) begin
                  dcnt_d = dcnt_q + CntW'(1);
               end else begin
                  dcnt_d  = '0;
                  state_d = StScan;
               end
            end
            StHold: begin
               if (row_low == 4'b0000) begin
                  if (hcnt_q + CntW'(1) == CntDone) begin
                     hcnt_d  = '0;
                     col_d   = col_q + 2'd1;
                     state_d = StScan;
                  end else begin
                     hcnt_d = hcnt_q + CntW'(1);
                  end
               end else begin
                  hcnt_d = '0;
               end
            end
            default: state_d = StScan;
         endcase

         // Acceptance shares the capture tick when one sample is enough.
         if (state_d == StDebounce && dcnt_d == CntDone) begin
            kv_d    = 1'b1;
            code_d  = key_map(cap_row_d, col_q);
            dcnt_d  = '0;
            hcnt_d  = '0;
            state_d = StHold;
         end
      end
   end

   // Outputs.
   always_comb begin
      col_n_w = ~(4'b0001 << col_q);
   end

   // Fed with the pre-register strobe so value changes in the key_valid cycle.
   keypad_digit_acc #(
      .DIGITS (DIGITS),
      .VAL_W  (VAL_W)
   ) u_acc (
      .clk       (clk),
      .rst       (rst),
      .key_valid (kv_d),
      .key_code  (code_d),
      .value     (value_w),
      .committed (committed_w),
      .commit    (commit_w)
   );

   assign kp.col_n     = col_n_w;
   assign kp.key_valid = kv_q;
   assign kp.key_code  = code_q;
   assign kp.value     = value_w;
   assign kp.committed = committed_w;
   assign kp.commit    = commit_w;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomised self-checking bench for keypad_scan_ctrl with a key-level model.
module tb_keypad_scan_ctrl;
   import keypad_pkg::*;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEB     = 3;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned VAL_W   = 14;
   localparam int unsigned MODULUS = 10 ** DIGITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_scan_ctrl_if #(.VAL_W(VAL_W)) kp ();

   keypad_scan_ctrl #(
      .CLK_DIV        (CLK_DIV),
      .DEBOUNCE_SCANS (DEB),
      .DIGITS         (DIGITS),
      .VAL_W          (VAL_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp.master)
   );

   // Physical matrix: key (r,c) at index r*4+c pulls row r low while column c is driven.
   logic [15:0] keys_down = '0;
   always_comb begin
      kp.row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys_down[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
         end
      end
   end

   key_code_t keymap [16] = '{KEY_1, KEY_2, KEY_3, KEY_A,
                              KEY_4, KEY_5, KEY_6, KEY_B,
                              KEY_7, KEY_8, KEY_9, KEY_C,
                              KEY_STAR, KEY_0, KEY_HASH, KEY_D};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model of the entry value.
   int unsigned m_value = 0;
   int unsigned m_committed = 0;

   task automatic model_apply(input key_code_t c);
      if (int'(c) <= 9)         m_value = (m_value * 10 + int'(c)) % MODULUS;
      else if (c == KEY_STAR)   m_value = 0;
      else if (c == KEY_D)      m_value = m_value / 10;
      else if (c == KEY_HASH)   m_committed = m_value;
   endtask

   // Event monitor.
   int          n_kv = 0;
   int          n_commit = 0;
   logic        kv_prev = 1'b0;
   logic        commit_prev = 1'b0;
   logic [31:0] pend_value = 0;

   always @(negedge clk) begin
      if (kp.key_valid === 1'b1) begin
         n_kv++;
         check_eq("kv_single_cycle", 32'(kv_prev), 0);
         check_eq("value_in_kv_cycle", 32'(kp.value), pend_value);
      end
      if (kp.commit === 1'b1) begin
         n_commit++;
         check_eq("commit_single_cycle", 32'(commit_prev), 0);
      end
      kv_prev     = kp.key_valid;
      commit_prev = kp.commit;
   end

   task automatic wait_ticks(input int n);
      repeat (n * CLK_DIV) @(negedge clk);
   endtask

   task automatic wait_col(input logic [3:0] want, input int budget, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (kp.col_n === want) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_value"}, 32'(kp.value), m_value);
      check_eq({tag, "_committed"}, 32'(kp.committed), m_committed);
   endtask

   task automatic press_key(input int idx, input int hold_ticks);
      int        kv0 = n_kv;
      int        cm0 = n_commit;
      key_code_t c   = keymap[idx];
      model_apply(c);
      pend_value = m_value;
      keys_down[idx] = 1'b1;
      wait_ticks(hold_ticks);
      keys_down[idx] = 1'b0;
      wait_ticks(8);
      check_eq("press_kv_count", n_kv - kv0, 1);
      check_eq("press_key_code", 32'(kp.key_code), 32'(c));
      check_eq("press_commit_count", n_commit - cm0, (c == KEY_HASH) ? 1 : 0);
      check_outputs("press");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int   kv0;
      logic seen;

      repeat (3) @(negedge clk);
      check_eq("rst_col_n", 32'(kp.col_n), 32'h0000000E);
      check_eq("rst_key_valid", 32'(kp.key_valid), 0);
      check_eq("rst_key_code", 32'(kp.key_code), 0);
      check_eq("rst_commit", 32'(kp.commit), 0);
      check_outputs("rst");
      rst = 1'b0;

      // 1 2 3 4 # -> 1234 committed; then 5 wraps to 2345.
      press_key(0, 12);
      press_key(1, 12);
      press_key(2, 12);
      press_key(4, 12);
      press_key(14, 12);
      press_key(5, 12);

      // Ghost: rows 0 and 1 low together on column 0.
      kv0 = n_kv;
      keys_down[0] = 1'b1;
      keys_down[4] = 1'b1;
      wait_col(4'b0111, 40, seen);
      check_eq("ghost_scan_moves", 32'(seen), 1);
      wait_ticks(10);
      keys_down[0] = 1'b0;
      keys_down[4] = 1'b0;
      wait_ticks(8);
      check_eq("ghost_no_kv", n_kv - kv0, 0);
      check_outputs("ghost");

      // D -> 234, * -> 0, A -> value unchanged.
      press_key(15, 12);
      press_key(12, 12);
      press_key(3, 14);

      // Hold '7' for ~50 ticks.
      kv0 = n_kv;
      model_apply(KEY_7);
      pend_value = m_value;
      keys_down[8] = 1'b1;
      for (int i = 0; i < 100 && n_kv == kv0; i++) @(negedge clk);
      check_eq("hold_kv_seen", n_kv - kv0, 1);
      for (int i = 0; i < 11; i++) begin
         wait_ticks(4);
         check_eq("hold_col_frozen", 32'(kp.col_n), 32'h0000000E);
      end
      keys_down[8] = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("release_col_held", 32'(kp.col_n), 32'h0000000E);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (kp.col_n !== 4'b1110) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("release_col_advances", 32'(seen), 1);
      wait_ticks(8);
      check_eq("hold_single_kv", n_kv - kv0, 1);
      check_outputs("hold");

      // Bounce '8': 2 ticks low, 1 tick high, five times.
      kv0 = n_kv;
      for (int i = 0; i < 5; i++) begin
         keys_down[9] = 1'b1;
         repeat (2 * CLK_DIV) @(negedge clk);
         keys_down[9] = 1'b0;
         repeat (CLK_DIV) @(negedge clk);
      end
      wait_ticks(8);
      check_eq("bounce_no_kv", n_kv - kv0, 0);
      check_outputs("bounce");

      // Random key sequence against the model.
      for (int i = 0; i < 24; i++) begin
         press_key(int'($urandom_range(0, 15)), int'($urandom_range(12, 20)));
      end

      // Reset in the middle of debouncing '9'.
      wait_col(4'b1101, 40, seen);
      check_eq("pre_rst_col1", 32'(seen), 1);
      keys_down[10] = 1'b1;
      wait_col(4'b1011, 20, seen);
      check_eq("pre_rst_col2", 32'(seen), 1);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      m_value = 0;
      m_committed = 0;
      check_eq("mid_rst_col_n", 32'(kp.col_n), 32'h0000000E);
      check_eq("mid_rst_key_valid", 32'(kp.key_valid), 0);
      check_eq("mid_rst_key_code", 32'(kp.key_code), 0);
      check_eq("mid_rst_commit", 32'(kp.commit), 0);
      check_outputs("mid_rst");
      kv0 = n_kv;
      keys_down[10] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_ticks(20);
      check_eq("post_rst_no_kv", n_kv - kv0, 0);
      check_outputs("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
